// File: rtl/msp_trace_buffer.sv
// msp_trace_buffer: instruction/IRQ trace recorder for the openMSP430 bench.
// Records one entry per decode into a circular register array, freezes on a
// PC-match trigger (plus post-trigger entries) or when full, then drains the
// captured entries oldest-first through a request/valid read port.
module msp_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int NTRIG = 2,
    parameter int CYC_W = 8,
    parameter int CNT_W = 32
) (
    input  logic                  mclk,
    input  logic                  puc_rst_n,
    input  logic                  decode,
    input  logic [15:0]           ir,
    input  logic [15:0]           pc,
    input  logic                  irq_detect,
    input  logic [3:0]            irq_num,
    input  logic                  arm,
    input  logic                  stop_mode,
    input  logic [NTRIG-1:0]      trig_en,
    input  logic [16*NTRIG-1:0]   trig_pc,
    input  logic [AW:0]           post_cnt,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [33+CYC_W-1:0]   rd_data,
    output logic [1:0]            state,
    output logic [AW:0]           fill_level,
    output logic [NTRIG-1:0]      trig_hit,
    output logic [CNT_W-1:0]      inst_number
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

    typedef struct packed {
        logic             irq;
        logic [15:0]      op;
        logic [15:0]      pc;
        logic [CYC_W-1:0] delta;
    } entry_t;

    localparam logic [AW:0] DEPTH_F = (AW+1)'(DEPTH);

    state_t           st;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      post_q;
    logic [CYC_W-1:0] cyc_cnt;
    entry_t           mem [DEPTH];

    // arm acts in the same cycle: a coincident decode sees a freshly
    // cleared, armed buffer
    state_t         rec_st;
    logic [AW-1:0]  wr_base, rd_base;
    logic [AW:0]    fill_base;
    logic [NTRIG-1:0] hit_base, match;
    logic           wr_en, full, trig_fire, rd_go;
    entry_t         wr_entry;

    for (genvar k = 0; k < NTRIG; k++) begin : g_match
        assign match[k] = trig_en[k] && !irq_detect && (pc == trig_pc[16*k +: 16]);
    end

    // Effective pre-update view of the buffer and the events of this cycle
    always_comb begin
        rec_st    = arm ? ARMED : st;
        wr_base   = arm ? '0 : wr_ptr;
        rd_base   = arm ? '0 : rd_ptr;
        fill_base = arm ? '0 : fill_level;
        hit_base  = arm ? '0 : trig_hit;
        full      = (fill_base == DEPTH_F);
        wr_en     = decode && (rec_st == ARMED || rec_st == POST);
        trig_fire = wr_en && (rec_st == ARMED) && !stop_mode && (|match);
        rd_go     = !arm && rd_req && (st == DONE) && (fill_level != '0);
        wr_entry.irq   = irq_detect;
        wr_entry.op    = irq_detect ? {12'h000, irq_num} : ir;
        wr_entry.pc    = pc;
        wr_entry.delta = arm ? '0 : cyc_cnt;
    end

    // Entry storage: plain register array, written only while recording
    always_ff @(posedge mclk) begin
        if (wr_en) mem[wr_base] <= wr_entry;
    end

    // Recording FSM, pointers, fill level and read port
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            st         <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            post_q     <= '0;
            trig_hit   <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            st         <= rec_st;
            wr_ptr     <= wr_base;
            rd_ptr     <= rd_base;
            fill_level <= fill_base;
            trig_hit   <= hit_base;
            rd_valid   <= rd_go;
            if (wr_en) begin
                wr_ptr <= wr_base + AW'(1);
                // full buffer: overwrite the oldest entry, read side follows
                if (full) rd_ptr     <= rd_base + AW'(1);
                else      fill_level <= fill_base + (AW+1)'(1);
                if (rec_st == ARMED) begin
                    if (stop_mode) begin
                        if (fill_base + (AW+1)'(1) == DEPTH_F) st <= DONE;
                    end else if (trig_fire) begin
                        trig_hit <= hit_base | match;
                        post_q   <= post_cnt;
                        st       <= (post_cnt == '0) ? DONE : POST;
                    end
                end else begin
                    post_q <= post_q - (AW+1)'(1);
                    if (post_q == (AW+1)'(1)) st <= DONE;
                end
            end
            if (rd_go) begin
                rd_data    <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + AW'(1);
                fill_level <= fill_level - (AW+1)'(1);
            end
        end
    end

    // Cycle-delta counter: restarts on arm and every decode, saturates
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n)                     cyc_cnt <= '0;
        else if (arm || decode)             cyc_cnt <= '0;
        else if (cyc_cnt != {CYC_W{1'b1}})  cyc_cnt <= cyc_cnt + CYC_W'(1);
    end

    // Decode counter runs in every state
    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n)  inst_number <= '0;
        else if (decode) inst_number <= inst_number + CNT_W'(1);
    end

    assign state = st;

endmodule

// File: tb/tb_msp_trace_buffer.sv
// Directed bench for msp_trace_buffer (default parameters).
module tb_msp_trace_buffer;

    logic        mclk = 1'b0;
    logic        puc_rst_n;
    logic        decode, irq_detect, arm, stop_mode, rd_req;
    logic [15:0] ir, pc;
    logic [3:0]  irq_num;
    logic [1:0]  trig_en;
    logic [31:0] trig_pc;
    logic [4:0]  post_cnt;
    logic        rd_valid;
    logic [40:0] rd_data;
    logic [1:0]  state;
    logic [4:0]  fill_level;
    logic [1:0]  trig_hit;
    logic [31:0] inst_number;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 mclk = ~mclk;

    msp_trace_buffer dut (
        .mclk(mclk), .puc_rst_n(puc_rst_n), .decode(decode), .ir(ir), .pc(pc),
        .irq_detect(irq_detect), .irq_num(irq_num), .arm(arm), .stop_mode(stop_mode),
        .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_data(rd_data), .state(state), .fill_level(fill_level),
        .trig_hit(trig_hit), .inst_number(inst_number)
    );

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge mclk); #1;
        arm = 1'b0;
    endtask

    task automatic do_decode(input logic [15:0] p, input logic [15:0] op,
                             input logic irq, input logic [3:0] num);
        pc = p; ir = op; irq_detect = irq; irq_num = num; decode = 1'b1;
        @(posedge mclk); #1;
        decode = 1'b0; irq_detect = 1'b0;
    endtask

    task automatic read_entry(output logic v, output logic [40:0] d);
        rd_req = 1'b1;
        @(posedge mclk); #1;
        rd_req = 1'b0;
        v = rd_valid;
        d = rd_data;
    endtask

    task automatic do_reset();
        puc_rst_n = 1'b0;
        #7;
        puc_rst_n = 1'b1;
        @(posedge mclk); #1;
    endtask

    task automatic test_reset();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state); end
        n_checks++; if (fill_level !== 5'd0) begin n_fail++; $display("FAIL reset_fill: got %0d exp 0", fill_level); end
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 41'd0) begin n_fail++; $display("FAIL reset_rd: got %b/%h exp 0/0", rd_valid, rd_data); end
        n_checks++; if (trig_hit !== 2'b00 || inst_number !== 32'd0) begin n_fail++; $display("FAIL reset_hit_inst: got %b/%0d exp 00/0", trig_hit, inst_number); end
    endtask

    task automatic test_reset_mid_record();
        trig_en = 2'b00; stop_mode = 1'b0;
        pulse_arm();
        for (int i = 0; i < 5; i++) do_decode(16'h1000 + 16'(2*i), 16'h4303, 1'b0, 4'h0);
        n_checks++; if (state !== 2'd1 || fill_level !== 5'd5 || inst_number !== 32'd5) begin
            n_fail++; $display("FAIL mid_record: got st=%0d fill=%0d inst=%0d exp 1/5/5", state, fill_level, inst_number); end
        @(negedge mclk);
        puc_rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0 || fill_level !== 5'd0 || inst_number !== 32'd0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got st=%0d fill=%0d inst=%0d v=%b exp 0/0/0/0", state, fill_level, inst_number, rd_valid); end
        #6;
        puc_rst_n = 1'b1;
        @(posedge mclk); #1;
    endtask

    task automatic test_wrap_trigger();
        logic v; logic [40:0] d; logic [40:0] exp_d;
        trig_pc = {16'hF004, 16'hF00A}; trig_en = 2'b01; post_cnt = 5'd3; stop_mode = 1'b0;
        pulse_arm();
        for (int i = 0; i < 20; i++) begin
            do_decode(16'hF000 + 16'(2*i), 16'h4000 + 16'(i), 1'b0, 4'h0);
            if (i == 5) begin
                n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL trig_to_post: got %0d exp 2", state); end
            end
        end
        n_checks++; if (state !== 2'd3 || fill_level !== 5'd9) begin n_fail++; $display("FAIL trig_done: got st=%0d fill=%0d exp 3/9", state, fill_level); end
        n_checks++; if (trig_hit !== 2'b01) begin n_fail++; $display("FAIL trig_hit_ch0: got %b exp 01", trig_hit); end
        n_checks++; if (inst_number !== 32'd20) begin n_fail++; $display("FAIL inst_count: got %0d exp 20", inst_number); end
        for (int i = 0; i < 9; i++) begin
            read_entry(v, d);
            exp_d = {1'b0, 16'h4000 + 16'(i), 16'hF000 + 16'(2*i), 8'h00};
            n_checks++; if (v !== 1'b1 || d !== exp_d) begin n_fail++; $display("FAIL trig_read%0d: got %b/%h exp 1/%h", i, v, d, exp_d); end
        end
        read_entry(v, d);
        n_checks++; if (v !== 1'b0 || d !== {1'b0, 16'h4008, 16'hF010, 8'h00} || fill_level !== 5'd0) begin
            n_fail++; $display("FAIL read_empty: got v=%b d=%h fill=%0d exp 0/held/0", v, d, fill_level); end
    endtask

    task automatic test_overwrite();
        logic v; logic [40:0] d;
        trig_pc = {16'h0000, 16'hF024}; trig_en = 2'b01; post_cnt = 5'd0; stop_mode = 1'b0;
        pulse_arm();
        for (int i = 0; i < 19; i++) do_decode(16'hF000 + 16'(2*i), 16'h5000 + 16'(i), 1'b0, 4'h0);
        n_checks++; if (state !== 2'd3 || fill_level !== 5'd16) begin n_fail++; $display("FAIL ovw_done: got st=%0d fill=%0d exp 3/16", state, fill_level); end
        for (int i = 0; i < 16; i++) begin
            read_entry(v, d);
            if (i == 0) begin
                n_checks++; if (v !== 1'b1 || d[23:8] !== 16'hF006) begin n_fail++; $display("FAIL ovw_first: got %b/%h exp 1/F006", v, d[23:8]); end
            end
            if (i == 15) begin
                n_checks++; if (v !== 1'b1 || d[23:8] !== 16'hF024 || d[39:24] !== 16'h5012) begin
                    n_fail++; $display("FAIL ovw_last: got %b/%h/%h exp 1/F024/5012", v, d[23:8], d[39:24]); end
            end
        end
    endtask

    task automatic test_stop_mode();
        logic v; logic [40:0] d;
        do_reset();
        trig_pc = {16'hF002, 16'hF000}; trig_en = 2'b11; stop_mode = 1'b1; post_cnt = 5'd0;
        pulse_arm();
        for (int i = 0; i < 16; i++) begin
            do_decode(16'hF000 + 16'(2*i), 16'h6000 + 16'(i), 1'b0, 4'h0);
            if (i == 14) begin
                n_checks++; if (state !== 2'd1 || trig_hit !== 2'b00) begin n_fail++; $display("FAIL stop_15th: got st=%0d hit=%b exp 1/00", state, trig_hit); end
            end
        end
        n_checks++; if (state !== 2'd3 || fill_level !== 5'd16) begin n_fail++; $display("FAIL stop_16th: got st=%0d fill=%0d exp 3/16", state, fill_level); end
        do_decode(16'hBEEF, 16'h7777, 1'b0, 4'h0);
        n_checks++; if (fill_level !== 5'd16 || inst_number !== 32'd17) begin n_fail++; $display("FAIL stop_17th: got fill=%0d inst=%0d exp 16/17", fill_level, inst_number); end
        for (int i = 0; i < 16; i++) begin
            read_entry(v, d);
            if (i == 0) begin
                n_checks++; if (d[23:8] !== 16'hF000) begin n_fail++; $display("FAIL stop_first: got %h exp F000", d[23:8]); end
            end
        end
        n_checks++; if (v !== 1'b1 || d[23:8] !== 16'hF01E) begin n_fail++; $display("FAIL stop_last: got %b/%h exp 1/F01E", v, d[23:8]); end
        stop_mode = 1'b0;
    endtask

    task automatic test_irq_delta();
        logic v; logic [40:0] d;
        trig_pc = {16'h0000, 16'hC000}; trig_en = 2'b01; post_cnt = 5'd0;
        pulse_arm();
        repeat (300) @(posedge mclk);
        #1;
        do_decode(16'hC000, 16'h1234, 1'b1, 4'hE);
        n_checks++; if (state !== 2'd1 || fill_level !== 5'd1) begin n_fail++; $display("FAIL irq_no_trig: got st=%0d fill=%0d exp 1/1", state, fill_level); end
        do_decode(16'hC000, 16'h5678, 1'b0, 4'h0);
        n_checks++; if (state !== 2'd3 || fill_level !== 5'd2) begin n_fail++; $display("FAIL irq_then_trig: got st=%0d fill=%0d exp 3/2", state, fill_level); end
        read_entry(v, d);
        n_checks++; if (v !== 1'b1 || d !== {1'b1, 16'h000E, 16'hC000, 8'hFF}) begin n_fail++; $display("FAIL irq_entry: got %b/%h exp 1/%h", v, d, {1'b1, 16'h000E, 16'hC000, 8'hFF}); end
        read_entry(v, d);
        n_checks++; if (v !== 1'b1 || d !== {1'b0, 16'h5678, 16'hC000, 8'h00}) begin n_fail++; $display("FAIL delta_zero: got %b/%h exp 1/%h", v, d, {1'b0, 16'h5678, 16'hC000, 8'h00}); end
    endtask

    task automatic test_back_to_back();
        trig_pc = {16'hA5A4, 16'h0000}; trig_en = 2'b10; post_cnt = 5'd0;
        pc = 16'hA5A4; ir = 16'h3C3C; irq_detect = 1'b0; decode = 1'b1; arm = 1'b1;
        @(posedge mclk); #1;
        decode = 1'b0; arm = 1'b0;
        n_checks++; if (state !== 2'd3 || fill_level !== 5'd1 || trig_hit !== 2'b10) begin
            n_fail++; $display("FAIL simul_arm: got st=%0d fill=%0d hit=%b exp 3/1/10", state, fill_level, trig_hit); end
        rd_req = 1'b1;
        @(posedge mclk); #1;
        n_checks++; if (rd_valid !== 1'b1 || rd_data[39:8] !== {16'h3C3C, 16'hA5A4} || rd_data[40] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: got %b/%h exp 1/03C3CA5A4xx", rd_valid, rd_data); end
        @(posedge mclk); #1;
        rd_req = 1'b0;
        n_checks++; if (rd_valid !== 1'b0 || fill_level !== 5'd0) begin n_fail++; $display("FAIL b2b_second: got v=%b fill=%0d exp 0/0", rd_valid, fill_level); end
    endtask

    initial begin
        puc_rst_n = 1'b0; decode = 1'b0; irq_detect = 1'b0; arm = 1'b0; stop_mode = 1'b0;
        rd_req = 1'b0; ir = '0; pc = '0; irq_num = '0; trig_en = '0; trig_pc = '0; post_cnt = '0;
        #12;
        test_reset();
        puc_rst_n = 1'b1;
        @(posedge mclk); #1;
        test_reset_mid_record();
        test_wrap_trigger();
        test_overwrite();
        test_stop_mode();
        test_irq_delta();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
